ram_1rw_arbiter: RTL and testbench
==================================

// Module: ram_1rw_arbiter
// PURPOSE
// - Shares one single-port (1RW) RAM between two requesters on the Hack-on-FPGA memory path.
//   Port 0 is the CPU data memory access. Port 1 is the screen/video refresh fetch.
// - Grants one access per cycle and drives the RAM address, write and write-data lines.
// - Returns read data through a per-port rvalid strobe that aligns with the RAM's
//   1-cycle registered read.
// - Sits between the CPU/video logic and the RAM instance.
// PARAMETERS
// - DW           16   data width, matches the RAM
// - AW           10   address width, matches the RAM
// - STARVE_LIMIT 4    fixed-priority mode: max consecutive denied cycles for port 1 before it is forced a grant (>=1)
// PORTS
// - clk          in   1    clock, all logic on posedge
// - rst          in   1    synchronous active-high reset
// - p0_req       in   1    port 0 request. Must hold req/write/addr/wdata stable until p0_gnt.
// - p0_write     in   1    port 0: 1 = write, 0 = read
// - p0_addr      in   AW   port 0 address
// - p0_wdata     in   DW   port 0 write data
// - p0_gnt       out  1    port 0 access accepted this cycle (combinational)
// - p0_rvalid    out  1    port 0 read data valid (registered)
// - p0_rdata     out  DW   port 0 read data, meaningful only when p0_rvalid=1
// - p1_req, p1_write, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
// - ram_addr     out  AW   RAM address
// - ram_write    out  1    RAM write enable
// - ram_wdata    out  DW   RAM write data
// - ram_rdata    in   DW   RAM read data, registered inside the RAM, valid 1 cycle after address
// BEHAVIOUR
// - Grant: at most one of p0_gnt/p1_gnt high per cycle. gnt=0 whenever that port's req=0.
//   A lone request is granted in the same cycle.
// - RAM drive: the granted port's addr/write/wdata are routed to the RAM in the grant cycle.
//   With no grant: ram_write=0, ram_addr=p0_addr, ram_wdata=p0_wdata.
// - Read latency: a read granted in cycle N gives pX_rvalid=1 in cycle N+1, with pX_rdata=ram_rdata.
//   Writes never raise rvalid. p0_rdata and p1_rdata both mirror ram_rdata; only rvalid qualifies them.
// - Back-to-back reads, either port, one per cycle: full throughput, 1 result per cycle.
// - Read in the cycle after a write to the same address returns the new data.
//   This is guaranteed by the RAM's sequential ordering.
// - Fixed-priority mode, macro undefined:
//   - Port 0 wins on contention.
//   - starve_cnt counts consecutive cycles with p1_req=1 and p1_gnt=0. It clears when p1 is
//     granted or p1_req=0.
//   - When starve_cnt==STARVE_LIMIT, port 1 wins the next contention. Port 0 waits.
//   - starve_cnt saturates at STARVE_LIMIT and never wraps.
// - Reset:
//   - p0_rvalid=0, p1_rvalid=0, starve_cnt=0, last-grant pointer=1 (so port 0 is favoured first).
//   - A read granted in the cycle rst is asserted produces no rvalid. Its pending result is dropped.
//   - Combinational gnt still follows req during rst, but grants issued while rst=1 have no
//     rvalid effect. Requesters must not issue requests during rst.
// CONFIGURATION
// - RAM_ARB_ROUND_ROBIN_EN defined:
//   - On contention the port not granted most recently wins. The last-grant pointer updates on every grant.
//   - STARVE_LIMIT and starve_cnt are unused; starve_cnt is held at 0.
// - RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority with the starvation guard described above.
// TESTING
// - Lone p0 write addr=5 wdata=16'h1234, then p0 read addr=5 ->
//   p0_gnt same cycle both times; p0_rvalid next cycle with p0_rdata=16'h1234; p1_rvalid stays 0.
// - Fixed mode, STARVE_LIMIT=4, p0 and p1 both hold read req continuously ->
//   p0 granted 4 cycles, p1 granted cycle 5, pattern repeats; no cycle with both gnt=1.
// - RR mode, both ports request continuously ->
//   grants alternate p0,p1,p0,p1 starting with p0 after reset.
// - p0 reads addr 1,2,3 back-to-back, RAM preloaded 10,20,30 ->
//   p0_rvalid high 3 consecutive cycles with rdata 10,20,30.
// - p1 read granted, rst=1 in the same cycle ->
//   p1_rvalid=0 next cycle; starve_cnt=0; first contention after reset goes to p0.
// - p1 write addr=7 data=16'hBEEF while p0 idle, then p1 read addr=7 ->
//   ram_write=1 for exactly 1 cycle; p1_rdata=16'hBEEF with p1_rvalid.

Source files
------------

// File: rtl/ram_1rw_arbiter_if.sv
// Bundle of both requester ports plus the shared 1RW RAM lines for ram_1rw_arbiter.
// The arbiter connects through the slave modport, requesters and the RAM through master.
interface ram_1rw_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic          p0_req;
    logic          p0_write;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_write;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  p0_req, p0_write, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_write, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_addr, ram_write, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output p0_req, p0_write, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_write, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_addr, ram_write, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_1rw_arbiter.sv
// Two-port arbiter in front of a single-port RAM (CPU data port 0, video fetch port 1).
// Optional macro RAM_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority with starvation guard.
module ram_1rw_arbiter #(
    parameter int DW           = 16,
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    ram_1rw_arbiter_if.slave bus
);
    logic          gnt0;
    logic          gnt1;
    logic          p1_first;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic          write_s;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // last_q = 1 means port 1 was granted most recently, so port 0 wins the next contention
    logic last_q, last_d;

    assign p1_first = ~last_q;

    // Pointer follows every grant
    always_comb begin
        last_d = last_q;
        if (gnt1) begin
            last_d = 1'b1;
        end else if (gnt0) begin
            last_d = 1'b0;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign p1_first = (starve_cnt_q == LIMIT);

    // Count consecutive denied cycles of port 1, saturating at the limit
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.p1_req || gnt1) begin
            starve_cnt_d = {CW{1'b0}};
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= {CW{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Grant decision: lone requests pass straight through, contention resolved by p1_first
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            if (p1_first) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = bus.p0_req;
            gnt1 = bus.p1_req;
        end
    end

    // RAM mux; idle cycles park on port 0's lines with write disabled
    always_comb begin
        addr_s  = bus.p0_addr;
        wdata_s = bus.p0_wdata;
        write_s = 1'b0;
        if (gnt1) begin
            addr_s  = bus.p1_addr;
            wdata_s = bus.p1_wdata;
            write_s = bus.p1_write;
        end else if (gnt0) begin
            write_s = bus.p0_write;
        end else begin
            write_s = 1'b0;
        end
    end

    // Granted reads return one cycle later, aligned with the RAM's registered output
    always_comb begin
        p0_rvalid_d = gnt0 & ~bus.p0_write;
        p1_rvalid_d = gnt1 & ~bus.p1_write;
    end

    // Read-valid strobes; reset also drops a read granted in the reset cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_rdata  = bus.ram_rdata;
    assign bus.p1_rdata  = bus.ram_rdata;
    assign bus.ram_addr  = addr_s;
    assign bus.ram_wdata = wdata_s;
    assign bus.ram_write = write_s;
endmodule

// File: tb/tb_ram_1rw_arbiter.sv
// Directed bench for ram_1rw_arbiter with a behavioural 1-cycle registered RAM.
module tb_ram_1rw_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] mem [1024];
    logic        e0;
    logic        e1;

    ram_1rw_arbiter_if #(.DW(16), .AW(10)) bus ();

    ram_1rw_arbiter #(.DW(16), .AW(10), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[1] = 16'd10;
        mem[2] = 16'd20;
        mem[3] = 16'd30;

        rst = 1'b1;
        bus.p0_req = 1'b0; bus.p0_write = 1'b0; bus.p0_addr = 10'd0; bus.p0_wdata = 16'h0000;
        bus.p1_req = 1'b0; bus.p1_write = 1'b0; bus.p1_addr = 10'd0; bus.p1_wdata = 16'h0000;
        tick();
        tick();
        check("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        check("rst_p0_gnt",    32'(bus.p0_gnt),    32'd0);
        check("rst_ram_write", 32'(bus.ram_write), 32'd0);
        rst = 1'b0;

        // Lone p0 write then read of address 5
        bus.p0_req = 1'b1; bus.p0_write = 1'b1; bus.p0_addr = 10'd5; bus.p0_wdata = 16'h1234;
        #1;
        check("p0w_gnt",       32'(bus.p0_gnt),    32'd1);
        check("p0w_p1_gnt",    32'(bus.p1_gnt),    32'd0);
        check("p0w_ram_write", 32'(bus.ram_write), 32'd1);
        check("p0w_ram_addr",  32'(bus.ram_addr),  32'd5);
        check("p0w_ram_wdata", 32'(bus.ram_wdata), 32'h1234);
        tick();
        check("p0w_no_rvalid", 32'(bus.p0_rvalid), 32'd0);
        bus.p0_write = 1'b0;
        #1;
        check("p0r_gnt",       32'(bus.p0_gnt),    32'd1);
        check("p0r_ram_write", 32'(bus.ram_write), 32'd0);
        tick();
        check("p0r_rvalid",    32'(bus.p0_rvalid), 32'd1);
        check("p0r_rdata",     32'(bus.p0_rdata),  32'h1234);
        check("p0r_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);

        // Back-to-back reads of addresses 1,2,3
        bus.p0_addr = 10'd1;
        tick();
        check("b2b_rvalid1", 32'(bus.p0_rvalid), 32'd1);
        check("b2b_rdata1",  32'(bus.p0_rdata),  32'd10);
        bus.p0_addr = 10'd2;
        tick();
        check("b2b_rvalid2", 32'(bus.p0_rvalid), 32'd1);
        check("b2b_rdata2",  32'(bus.p0_rdata),  32'd20);
        bus.p0_addr = 10'd3;
        tick();
        check("b2b_rvalid3", 32'(bus.p0_rvalid), 32'd1);
        check("b2b_rdata3",  32'(bus.p0_rdata),  32'd30);
        bus.p0_req = 1'b0;
        tick();
        check("b2b_idle_rvalid", 32'(bus.p0_rvalid), 32'd0);

        // p1 write BEEF to 7 while p0 idle, then read it back
        bus.p1_req = 1'b1; bus.p1_write = 1'b1; bus.p1_addr = 10'd7; bus.p1_wdata = 16'hBEEF;
        #1;
        check("p1w_gnt",       32'(bus.p1_gnt),    32'd1);
        check("p1w_p0_gnt",    32'(bus.p0_gnt),    32'd0);
        check("p1w_ram_write", 32'(bus.ram_write), 32'd1);
        check("p1w_ram_addr",  32'(bus.ram_addr),  32'd7);
        check("p1w_ram_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        tick();
        check("p1w_no_rvalid", 32'(bus.p1_rvalid), 32'd0);
        bus.p1_write = 1'b0;
        #1;
        check("p1r_ram_write", 32'(bus.ram_write), 32'd0);
        check("p1r_gnt",       32'(bus.p1_gnt),    32'd1);
        tick();
        check("p1r_rvalid",    32'(bus.p1_rvalid), 32'd1);
        check("p1r_rdata",     32'(bus.p1_rdata),  32'hBEEF);
        check("p1r_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);

        // Continuous contention: p0 reads addr 1 (10), p1 reads addr 2 (20)
        bus.p0_req = 1'b1; bus.p0_write = 1'b0; bus.p0_addr = 10'd1;
        bus.p1_req = 1'b1; bus.p1_write = 1'b0; bus.p1_addr = 10'd2;
        for (int i = 0; i < 9; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            e1 = ((i % 2) == 1);
`else
            e1 = ((i % 5) == 4);
`endif
            e0 = ~e1;
            #1;
            check($sformatf("cont%0d_p0_gnt", i),   32'(bus.p0_gnt),               32'(e0));
            check($sformatf("cont%0d_p1_gnt", i),   32'(bus.p1_gnt),               32'(e1));
            check($sformatf("cont%0d_both", i),     32'(bus.p0_gnt & bus.p1_gnt),  32'd0);
            check($sformatf("cont%0d_addr", i),     32'(bus.ram_addr),             e1 ? 32'd2 : 32'd1);
            tick();
            check($sformatf("cont%0d_p0_rv", i),    32'(bus.p0_rvalid),            32'(e0));
            check($sformatf("cont%0d_p1_rv", i),    32'(bus.p1_rvalid),            32'(e1));
            check($sformatf("cont%0d_rdata", i),    32'(bus.p0_rdata),             e1 ? 32'd20 : 32'd10);
        end

        // Reset asserted in the same cycle as a p1 read grant
        bus.p0_req = 1'b0;
        bus.p1_addr = 10'd7;
        rst = 1'b1;
        #1;
        check("rstg_p1_gnt", 32'(bus.p1_gnt), 32'd1);
        tick();
        check("rstg_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        check("rstg_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
        bus.p1_req = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
        bus.p0_req = 1'b1; bus.p0_addr = 10'd3;
        bus.p1_req = 1'b1;
        #1;
        check("post_rst_p0_gnt", 32'(bus.p0_gnt), 32'd1);
        check("post_rst_p1_gnt", 32'(bus.p1_gnt), 32'd0);
        tick();
        check("post_rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
        check("post_rst_p0_rdata",  32'(bus.p0_rdata),  32'd30);
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
